// File: rtl/axi_burst_slave_mem.sv
// AXI3 slave memory model: independent single-outstanding write and read burst engines
// over a byte-addressed array, with FIXED/INCR/WRAP sequencing, narrow beats and strobes.
module axi_burst_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int DB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(DB);
  localparam int MEM_AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [7:0] mem [MEM_BYTES];

  function automatic logic wrap_len_ok(input logic [LEN_WIDTH-1:0] len);
    return (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
           (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
  endfunction

  function automatic logic size_bad(input logic [2:0] size);
    return (32'd1 << size) > 32'(DB);
  endfunction

  function automatic logic burst_bad(input logic [LEN_WIDTH-1:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return size_bad(size) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return addr < ADDR_WIDTH'(MEM_BYTES);
  endfunction

  // Bad WRAP lengths and the reserved burst code fall through to INCR sequencing.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [LEN_WIDTH-1:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] n, b;
    n = ADDR_WIDTH'(1) << size;
    b = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * n;
    if (burst == 2'b00) return addr;
    if ((burst == 2'b10) && wrap_len_ok(len)) return (addr & ~(b - 1'b1)) | ((addr + n) & (b - 1'b1));
    return (addr & ~(n - 1'b1)) + n;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] w;
    logic [MEM_AW-1:0]     base;
    w = '0;
    base = addr[MEM_AW-1:0] & ~MEM_AW'(DB - 1);
    if (in_range(addr))
      for (int i = 0; i < DB; i++) w[8*i +: 8] = mem[base + MEM_AW'(i)];
    return w;
  endfunction

  w_state_t              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LEN_WIDTH-1:0]  w_len, w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_fire, w_last_beat, w_beat_err;
  logic [DB-1:0]         lane_en;
  logic [MEM_AW-1:0]     w_base;
  int                    n_w, lo_w;

  assign w_fire      = (w_state == W_DATA) && WVALID && WREADY;
  assign w_last_beat = (w_beat == w_len);
  assign w_beat_err  = !in_range(w_addr) || (WID != w_id) || (WLAST != w_last_beat);
  assign w_base      = w_addr[MEM_AW-1:0] & ~MEM_AW'(DB - 1);

  // Only lanes inside the beat's aligned size window may be written.
  always_comb begin
    lane_en = '0;
    n_w     = 32'd1 << w_size;
    lo_w    = 32'(w_addr[LANE_W-1:0]) & ~(n_w - 1);
    if (w_fire && in_range(w_addr) && !size_bad(w_size))
      for (int i = 0; i < DB; i++)
        if (WSTRB[i] && (i >= lo_w) && (i < lo_w + n_w)) lane_en[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DB; i++)
      if (lane_en[i]) mem[w_base + MEM_AW'(i)] <= WDATA[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWREADY && AWVALID) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_id    <= AWID;
            BID     <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_beat  <= '0;
            w_err   <= burst_bad(AWLEN, AWSIZE, AWBURST);
            w_state <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_beat <= w_beat + 1'b1;
            w_err  <= w_err | w_beat_err;
            if (w_last_beat) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BRESP   <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next;
  logic [LEN_WIDTH-1:0]  r_len, r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_serr, ar_serr;

  assign r_next  = next_addr(r_addr, r_len, r_size, r_burst);
  assign ar_serr = burst_bad(ARLEN, ARSIZE, ARBURST);

  // RDATA is loaded on the handshake edge, so a same-cycle write is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARREADY && ARVALID) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RID     <= ARID;
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_beat  <= '0;
            r_serr  <= ar_serr;
            RDATA   <= read_word(ARADDR);
            RRESP   <= (ar_serr || !in_range(ARADDR)) ? 2'b10 : 2'b00;
            RLAST   <= (ARLEN == '0);
            r_state <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_beat <= r_beat + 1'b1;
              RDATA  <= read_word(r_next);
              RRESP  <= (r_serr || !in_range(r_next)) ? 2'b10 : 2'b00;
              RLAST  <= ((r_beat + 1'b1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Directed plus randomized bench for axi_burst_slave_mem against a byte-array reference model.
module tb_axi_burst_slave_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_burst_slave_mem dut (
    .clk(clk), .reset(reset),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  bit [7:0]    mdl [4096];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wrap_ok(input int len);
    return len == 1 || len == 3 || len == 7 || len == 15;
  endfunction

  // Beat k address in closed form from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int len, input int size,
                                            input int burst, input int k);
    logic [31:0] n, b, base;
    n = 32'd1 << size;
    if (burst == 0) return addr;
    if (burst == 2 && wrap_ok(len)) begin
      b = 32'(len + 1) * n;
      base = (addr / b) * b;
      return base + ((addr - base) + 32'(k) * n) % b;
    end
    if (k == 0) return addr;
    return (addr / n) * n + 32'(k) * n;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] ba);
    logic [31:0] wa;
    if (ba >= 32'd4096) return 32'h0;
    wa = (ba / 4) * 4;
    return {mdl[wa + 3], mdl[wa + 2], mdl[wa + 1], mdl[wa]};
  endfunction

  function automatic bit static_err(input int len, input int size, input int burst);
    return ((1 << size) > 4) || burst == 3 || (burst == 2 && !wrap_ok(len));
  endfunction

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                    input int burst, input bit wid_bad, input bit wlast_bad, input int bdelay);
    bit err, hs;
    logic [31:0] ba;
    int n, lo;
    n = 1 << size;
    err = static_err(len, size, burst) || wid_bad || wlast_bad;
    for (int k = 0; k <= len; k++) begin
      ba = beat_addr(addr, len, size, burst, k);
      if (ba >= 32'd4096) err = 1'b1;
      else if (n <= 4) begin
        lo = (int'(ba % 4) / n) * n;
        for (int i = lo; i < lo + n; i++)
          if (ws[k][i]) mdl[(ba / 4) * 4 + 32'(i)] = wd[k][8*i +: 8];
      end
    end
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      hs = AWREADY;
      @(posedge clk); #1;
    end
    AWVALID = 1'b0;
    if (!hs) chk("aw_timeout", hs, 1'b1);
    for (int k = 0; k <= len; k++) begin
      WID = (wid_bad && k == 0) ? id ^ 4'h1 : id;
      WDATA = wd[k]; WSTRB = ws[k];
      WLAST = (k == len) ^ (wlast_bad && k == 0);
      WVALID = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 50 && !hs; t++) begin
        hs = WREADY;
        @(posedge clk); #1;
      end
      if (!hs) chk("w_timeout", hs, 1'b1);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      hs = BVALID;
      if (!hs) begin @(posedge clk); #1; end
    end
    if (!hs) chk("b_timeout", hs, 1'b1);
    for (int d = 0; d < bdelay; d++) begin
      chk("b_hold_valid", BVALID, 1'b1);
      chk("b_hold_id", BID, id);
      @(posedge clk); #1;
    end
    BREADY = 1'b1;
    chk("bid", BID, id);
    chk("bresp", BRESP, err ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    BREADY = 1'b0;
    chk("b_drop", BVALID, 1'b0);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                    input int burst, input bit toggle);
    bit hs, pend, serr;
    logic [31:0] ba, pdata;
    logic plast;
    int k, cyc;
    serr = static_err(len, size, burst);
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      hs = ARREADY;
      @(posedge clk); #1;
    end
    ARVALID = 1'b0;
    if (!hs) chk("ar_timeout", hs, 1'b1);
    k = 0; cyc = 0; pend = 1'b0; pdata = '0; plast = 1'b0;
    while (k <= len && cyc < 300) begin
      RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
      if (RVALID) begin
        if (pend) begin
          chk("r_hold_data", RDATA, pdata);
          chk("r_hold_last", RLAST, plast);
        end
        if (RREADY) begin
          ba = beat_addr(addr, len, size, burst, k);
          chk("rid", RID, id);
          chk("rdata", RDATA, mword(ba));
          chk("rresp", RRESP, (serr || ba >= 32'd4096) ? 2'b10 : 2'b00);
          chk("rlast", RLAST, k == len);
          k++;
          pend = 1'b0;
        end else begin
          pend = 1'b1; pdata = RDATA; plast = RLAST;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    RREADY = 1'b0;
    if (k <= len) chk("r_timeout", k, len + 1);
    chk("r_done", RVALID, 1'b0);
  endtask

  initial begin
    int burst, size, len, n;
    logic [31:0] addr;
    reset = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_rlast", RLAST, 1'b0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_bid", BID, 4'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_awready", AWREADY, 1'b1);
    chk("rel_arready", ARREADY, 1'b1);

    // Abort a write burst mid-flight with a 3-cycle reset.
    AWID = 4'h3; AWADDR = 32'h200; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WID = 4'h3; WDATA = 32'hDEAD0000; WSTRB = 4'hF; WVALID = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    WVALID = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midrst_bvalid", BVALID, 1'b0);
      chk("midrst_rvalid", RVALID, 1'b0);
      chk("midrst_wready", WREADY, 1'b0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrel_awready", AWREADY, 1'b1);
    chk("midrel_arready", ARREADY, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk("midrel_no_b", BVALID, 1'b0);
      @(posedge clk); #1;
    end

    // Clear the working region 0x000-0x3FF.
    for (int k = 0; k < 16; k++) begin wd[k] = 32'h0; ws[k] = 4'hF; end
    for (int b = 0; b < 16; b++) wr(4'h1, 32'(b * 64), 15, 2, 1, 0, 0, 0);

    for (int k = 0; k < 4; k++) wd[k] = 32'hA0 + 32'(k);
    wr(4'h5, 32'h10, 3, 2, 1, 0, 0, 0);
    rd(4'h9, 32'h10, 3, 2, 1, 0);

    for (int k = 0; k < 4; k++) wd[k] = 32'hC0 + 32'(k);
    wr(4'h2, 32'h30, 3, 2, 1, 0, 0, 0);
    rd(4'hA, 32'h38, 3, 2, 2, 0);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    wr(4'h2, 32'h101, 0, 0, 1, 0, 0, 0);
    rd(4'h4, 32'h100, 0, 2, 1, 0);

    wd[0] = 32'h5555AAAA; wd[1] = 32'h12345678; ws[1] = 4'hF;
    wr(4'h6, 32'hFFC, 1, 2, 1, 0, 0, 0);
    rd(4'h7, 32'hFFC, 1, 2, 1, 0);

    for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    wr(4'hB, 32'h180, 7, 2, 1, 0, 0, 5);
    rd(4'hC, 32'h180, 7, 2, 1, 1);

    // Error bursts: reserved code, bad WRAP length, oversize beat, WID and WLAST faults.
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'(($urandom % 15) + 1); end
    wr(4'h1, 32'h80, 3, 2, 3, 0, 0, 0);
    rd(4'h1, 32'h80, 3, 2, 3, 0);
    wr(4'h2, 32'h90, 2, 2, 2, 0, 0, 0);
    rd(4'h2, 32'h90, 2, 2, 1, 0);
    wr(4'h3, 32'hA0, 1, 3, 1, 0, 0, 0);
    rd(4'h3, 32'hA0, 3, 2, 1, 0);
    wr(4'h4, 32'hC0, 1, 2, 1, 1, 0, 0);
    wr(4'h5, 32'hD0, 1, 2, 1, 0, 1, 0);
    rd(4'h5, 32'hC0, 7, 2, 1, 1);

    for (int it = 0; it < 20; it++) begin
      burst = $urandom_range(0, 2);
      size = $urandom_range(0, 2);
      n = 1 << size;
      if (burst == 2) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else len = $urandom_range(0, 15);
      addr = 32'($urandom_range(0, 32'h3BF)) & ~32'(n - 1);
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      wr(4'($urandom), addr, len, size, burst, 0, 0, $urandom_range(0, 2));
      rd(4'($urandom), addr, len, size, burst, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_slave_mem.md
Name: axi_burst_slave_mem

Overview:
Parametrised AXI3 slave memory model. It replaces the fixed 32-bit, 4096-byte slave_mem array behind the top design. It accepts write and read bursts on independent channels, supports FIXED/INCR/WRAP bursts, narrow transfers and byte strobes, and returns OKAY/SLVERR responses. The bench and BFM use it as the reference-correct slave endpoint.

Parameters:
DATA_WIDTH, 32, data bus width in bits (32/64/128).
ADDR_WIDTH, 32, AxADDR width.
ID_WIDTH, 4, AWID/WID/BID/ARID/RID width.
LEN_WIDTH, 4, AxLEN width (beats = LEN+1).
MEM_BYTES, 4096, memory depth in bytes (power of 2).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
AWID/AWADDR/AWLEN  in  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH  write address, id, length
AWSIZE  in  3  bytes per beat = 2^AWSIZE
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1 ; AWREADY  out  1  write-address handshake
WID  in  ID_WIDTH ; WDATA  in  DATA_WIDTH ; WSTRB  in  DATA_WIDTH/8 ; WLAST  in  1  write data
WVALID  in  1 ; WREADY  out  1  write-data handshake
BID  out  ID_WIDTH ; BRESP  out  2 ; BVALID  out  1 ; BREADY  in  1  write response
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  as AW*  read address
ARREADY  out  1  read-address ready
RID  out  ID_WIDTH ; RDATA  out  DATA_WIDTH ; RRESP  out  2 ; RLAST  out  1 ; RVALID  out  1 ; RREADY  in  1  read data

Behaviour:
- Reset: clk-edge sampled reset drives AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST low. BID, RID, RDATA, BRESP, RRESP reset to 0. Memory contents are not reset. Reset mid-burst aborts both FSMs with no response. Ready signals rise the cycle after reset deasserts.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; one write outstanding.
  - W_IDLE: AWREADY=1. AW handshake captures id, addr, len, size, burst. Beat counter cleared, error flag cleared.
  - W_DATA: WREADY=1. Each W handshake writes byte lanes where WSTRB=1 AND the lane lies inside the current beat's size window. Beat count == len moves to W_RESP.
  - W_RESP: BVALID=1, BID=captured AWID. BVALID holds with BID/BRESP stable until BREADY. Then W_IDLE, with AWREADY=1 the next cycle.
  - BRESP=10 (SLVERR) if any of these occur, else 00: a beat address >= MEM_BYTES (that beat's write suppressed); WID != AWID; WLAST != (beat==len) on any beat; 2^AWSIZE > DATA_WIDTH/8 (all writes suppressed); AWBURST=11 (treated as INCR).
- Read FSM R_IDLE -> R_DATA -> R_IDLE; one read outstanding, independent of write.
  - R_IDLE: ARREADY=1. On AR handshake, RVALID asserts the next cycle.
  - R_DATA: RDATA is the full aligned DATA_WIDTH word containing the beat address, registered. RID=ARID. RLAST=1 on beat len only. RVALID/RDATA/RLAST hold until RREADY.
  - RRESP=10 per beat on the same address/size/burst errors; RDATA=0 for out-of-range beats. The last-beat handshake returns to R_IDLE.
- Address sequencing, with N=2^size:
  - FIXED: address is constant.
  - INCR: next = (addr & ~(N-1)) + N. An unaligned first beat is allowed; later beats are aligned.
  - WRAP: boundary B=(len+1)*N; next = (addr & ~(B-1)) | ((addr+N) & (B-1)). len not in {1,3,7,15} gives SLVERR, and the burst proceeds as INCR.
  - All address arithmetic is ADDR_WIDTH wide, wrapping modulo 2^ADDR_WIDTH.
- Same-cycle write beat and read of the same address: the read returns old data; the write is visible from the next cycle.

Test Plan:
1. Reset high 3 cycles mid-write burst -> BVALID/RVALID=0, no B response issued; after release AWREADY=ARREADY=1 next cycle.
2. INCR write AWADDR=0x10, AWLEN=3, AWSIZE=2, data 0xA0..0xA3, WSTRB=F -> BRESP=00, BID=AWID. Read-back of the same burst gives 0xA0..0xA3, RLAST on beat 3 only.
3. WRAP read ARADDR=0x38, ARLEN=3, ARSIZE=2 -> beat addresses 0x38, 0x3C, 0x30, 0x34.
4. Narrow write AWSIZE=0, AWADDR=0x101, WSTRB=F, WDATA=0x11223344 -> only byte 0x101 written (0x33); word 0x100 reads 0x00003300 from cleared memory.
5. Write AWADDR=MEM_BYTES-4, AWLEN=1, AWSIZE=2 -> beat 0 written, beat 1 suppressed, BRESP=10.
6. BREADY held low 5 cycles, RREADY toggling every other cycle -> BVALID/BID stable throughout; each RDATA beat held until accepted; no beats lost or repeated.
